// File: rtl/ascon_permutation_if.sv
`default_nettype none
// ============================================================================
// ascon_permutation_if : controller <-> permutation engine handshake bundle
// Rev 1.0
// ============================================================================
interface ascon_permutation_if;
    logic         start;
    logic [1:0]   round_sel;
    logic [319:0] state_in;
    logic [319:0] state_out;
    logic         busy;
    logic         done;

    modport master (
        output start, round_sel, state_in,
        input  state_out, busy, done
    );

    modport slave (
        input  start, round_sel, state_in,
        output state_out, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/ascon_permutation.sv
`default_nettype none
// ============================================================================
// ascon_permutation : iterative Ascon p^a engine (a = 12/8/6), UNROLL rounds/clk
// Rev 1.0
// ============================================================================
module ascon_permutation #(
    parameter int UNROLL = 1
) (
    input  wire logic           clk,
    input  wire logic           rst,
    ascon_permutation_if.slave  bus
);

    localparam logic [3:0] c_STEP      = 4'(UNROLL);
    localparam logic [3:0] c_LAST_EXCL = 4'd12;

    if (UNROLL != 1 && UNROLL != 2) begin : g_bad_unroll
        $error("ascon_permutation: UNROLL must be 1 or 2");
    end

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fsm_t;

    fsm_t         r_fsm;
    logic [319:0] r_state;
    logic [3:0]   r_round;
    logic         r_busy;
    logic         r_done;

    logic [319:0] w_next;
    logic [3:0]   w_first;
    logic [3:0]   w_round_nxt;

    function automatic logic [63:0] ror(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    // One full round: constant addition, bitsliced S-box, linear diffusion.
    function automatic logic [319:0] ascon_round(input logic [319:0] s, input logic [3:0] idx);
        logic [63:0] x0, x1, x2, x3, x4;
        logic [63:0] t0, t1, t2, t3, t4;
        logic [7:0]  c;
        {x0, x1, x2, x3, x4} = s;
        c  = {4'hf - idx, idx};
        x2 = x2 ^ {56'd0, c};

        x0 = x0 ^ x4;
        x4 = x4 ^ x3;
        x2 = x2 ^ x1;
        t0 = ~x0 & x1;
        t1 = ~x1 & x2;
        t2 = ~x2 & x3;
        t3 = ~x3 & x4;
        t4 = ~x4 & x0;
        x0 = x0 ^ t1;
        x1 = x1 ^ t2;
        x2 = x2 ^ t3;
        x3 = x3 ^ t4;
        x4 = x4 ^ t0;
        x1 = x1 ^ x0;
        x0 = x0 ^ x4;
        x3 = x3 ^ x2;
        x2 = ~x2;

        x0 = x0 ^ ror(x0, 19) ^ ror(x0, 28);
        x1 = x1 ^ ror(x1, 61) ^ ror(x1, 39);
        x2 = x2 ^ ror(x2, 1)  ^ ror(x2, 6);
        x3 = x3 ^ ror(x3, 10) ^ ror(x3, 17);
        x4 = x4 ^ ror(x4, 7)  ^ ror(x4, 41);
        return {x0, x1, x2, x3, x4};
    endfunction

    always_comb begin
        w_next = r_state;
        for (int k = 0; k < UNROLL; k++) begin
            w_next = ascon_round(w_next, r_round + 4'(k));
        end
    end

    // p12 starts at round 0, p8 at 4, p6 at 6; the reserved code runs p12.
    always_comb begin
        case (bus.round_sel)
            2'd1:    w_first = 4'd4;
            2'd2:    w_first = 4'd6;
            default: w_first = 4'd0;
        endcase
    end

    assign w_round_nxt = r_round + c_STEP;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fsm   <= IDLE;
            r_state <= '0;
            r_round <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_fsm)
                IDLE: begin
                    if (bus.start) begin
                        r_state <= bus.state_in;
                        r_round <= w_first;
                        r_busy  <= 1'b1;
                        r_fsm   <= RUN;
                    end
                end
                RUN: begin
                    r_state <= w_next;
                    r_round <= w_round_nxt;
                    if (w_round_nxt == c_LAST_EXCL) begin
                        r_fsm  <= IDLE;
                        r_busy <= 1'b0;
                        r_done <= 1'b1;
                    end
                end
                default: r_fsm <= IDLE;
            endcase
        end
    end

    assign bus.state_out = r_state;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;

endmodule
`default_nettype wire
